// File: rtl/tlc_pkg.sv
// tlc_pkg
// Shared definitions for the traffic light phase sequencer:
//   - state_e      : phase state encoding (also exported on the debug port)
//   - LAMP_*       : one-hot {R,Y,G} lamp encodings, LAMP_OFF for a dark lamp
//   - DEF_*        : default phase duration codes (timer final_value)
//   - lamp_decode  : maps a state and blink phase to the {ns,ew} lamp pair
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALL_RED_A = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALL_RED_B = 3'd5,
    ST_FLASH     = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int DEF_N          = 13;
  localparam int DEF_T_GREEN_NS = 999;
  localparam int DEF_T_GREEN_EW = 499;
  localparam int DEF_T_YELLOW   = 199;
  localparam int DEF_T_ALL_RED  = 49;
  localparam int DEF_T_FLASH    = 249;

  // Returns {ns_light, ew_light}. In FLASH both lamps blink together:
  // blink phase 0 shows NS yellow / EW red, blink phase 1 leaves both dark.
  function automatic logic [5:0] lamp_decode(input state_e s, input logic blink);
    logic [5:0] lamps;
    lamps = {LAMP_R, LAMP_R};
    case (s)
      ST_NS_GREEN:  lamps = {LAMP_G, LAMP_R};
      ST_NS_YELLOW: lamps = {LAMP_Y, LAMP_R};
      ST_EW_GREEN:  lamps = {LAMP_R, LAMP_G};
      ST_EW_YELLOW: lamps = {LAMP_R, LAMP_Y};
      ST_FLASH:     lamps = blink ? {LAMP_OFF, LAMP_OFF} : {LAMP_Y, LAMP_R};
      default:      lamps = {LAMP_R, LAMP_R};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tlc_req_latch.sv
// tlc_req_latch
// Sticky request flag. Set by a request input in any cycle, cleared when the
// request is served. A set and a clear in the same cycle resolve to clear,
// because that request is consumed directly by the serving edge.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset, flag cleared
//   set_i  : request input (level or pulse)
//   clr_i  : request served this cycle
//   pend_o : registered pending flag
module tlc_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic pend_o
);

  logic pend_q, pend_d;

  // Clear is evaluated last so it takes priority over a simultaneous set.
  always_comb begin
    pend_d = pend_q;
    if (set_i) pend_d = 1'b1;
    if (clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/tlc_phase_ctrl.sv
// tlc_phase_ctrl
// Phase sequencer for a two-road intersection (NS main road, EW side road).
// It feeds the phase timer its final_value and advances on timer_done, latches
// side-road car and pedestrian requests, and drives lamps and the walk signal.
// A night mode replaces the normal cycle with a common yellow/red flash.
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset (the timer resets alongside)
//   timer_done  : one-cycle pulse ending the current phase
//   side_car    : EW vehicle sensor
//   ped_req     : pedestrian button
//   night_mode  : request flashing operation
//   final_value : duration code of the current phase, to the timer
//   ns_light    : NS lamp, one-hot {R,Y,G} or dark
//   ew_light    : EW lamp, one-hot {R,Y,G} or dark
//   walk        : pedestrian crossing of the NS road permitted
//   phase       : current state encoding, for debug
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int T_GREEN_NS = DEF_T_GREEN_NS,
  parameter int T_GREEN_EW = DEF_T_GREEN_EW,
  parameter int T_YELLOW   = DEF_T_YELLOW,
  parameter int T_ALL_RED  = DEF_T_ALL_RED,
  parameter int T_FLASH    = DEF_T_FLASH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         timer_done,
  input  logic         side_car,
  input  logic         ped_req,
  input  logic         night_mode,
  output logic [N-1:0] final_value,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic         walk,
  output logic [2:0]   phase
);

  // Every duration code must be representable on the timer's N-bit compare.
  if (T_GREEN_NS >= (2**N) || T_GREEN_EW >= (2**N) || T_YELLOW >= (2**N) ||
      T_ALL_RED >= (2**N) || T_FLASH >= (2**N)) begin : g_param_check
    $error("tlc_phase_ctrl: a phase code parameter does not fit in N bits");
  end

  state_e       state_q, state_d;
  logic         blink_q, blink_d;
  logic         walk_q, walk_d;
  logic [N-1:0] final_q, final_d;
  logic [2:0]   ns_q, ns_d, ew_q, ew_d;
  logic         enter_ew;
  logic         car_pend, ped_pend;

  function automatic logic [N-1:0] code_of(input state_e s);
    logic [N-1:0] code;
    case (s)
      ST_NS_GREEN:                code = N'(T_GREEN_NS);
      ST_EW_GREEN:                code = N'(T_GREEN_EW);
      ST_NS_YELLOW, ST_EW_YELLOW: code = N'(T_YELLOW);
      ST_FLASH:                   code = N'(T_FLASH);
      default:                    code = N'(T_ALL_RED);
    endcase
    return code;
  endfunction

  // Both requests are dropped on the edge that enters EW_GREEN; a request
  // seen on that very edge is served through walk rather than kept pending.
  tlc_req_latch u_car_latch (
    .clk    (clk),
    .reset  (reset),
    .set_i  (side_car),
    .clr_i  (enter_ew),
    .pend_o (car_pend)
  );

  tlc_req_latch u_ped_latch (
    .clk    (clk),
    .reset  (reset),
    .set_i  (ped_req),
    .clr_i  (enter_ew),
    .pend_o (ped_pend)
  );

  // Next state and next registered outputs. Nothing moves without timer_done;
  // on a timer_done edge final_value is reloaded even when the state repeats,
  // so a held NS_GREEN or a continuing FLASH is re-armed for a full phase.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    if (timer_done) begin
      case (state_q)
        ST_NS_GREEN:
          if (car_pend || ped_pend || night_mode) state_d = ST_NS_YELLOW;
        ST_NS_YELLOW: state_d = ST_ALL_RED_A;
        ST_ALL_RED_A: state_d = night_mode ? ST_FLASH : ST_EW_GREEN;
        ST_EW_GREEN:  state_d = ST_EW_YELLOW;
        ST_EW_YELLOW: state_d = ST_ALL_RED_B;
        ST_ALL_RED_B: state_d = night_mode ? ST_FLASH : ST_NS_GREEN;
        ST_FLASH:     state_d = night_mode ? ST_FLASH : ST_ALL_RED_B;
        default:      state_d = ST_ALL_RED_B;
      endcase
      // Flash always starts on the lit half and toggles once per half-period.
      blink_d = (state_q == ST_FLASH && state_d == ST_FLASH) ? ~blink_q : 1'b0;
    end

    enter_ew = timer_done && (state_q == ST_ALL_RED_A) && (state_d == ST_EW_GREEN);

    walk_d = 1'b0;
    if (state_d == ST_EW_GREEN) walk_d = enter_ew ? (ped_pend | ped_req) : walk_q;

    final_d = timer_done ? code_of(state_d) : final_q;
    {ns_d, ew_d} = lamp_decode(state_d, blink_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ALL_RED_B;
      blink_q <= 1'b0;
      walk_q  <= 1'b0;
      final_q <= N'(T_ALL_RED);
      ns_q    <= LAMP_R;
      ew_q    <= LAMP_R;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      walk_q  <= walk_d;
      final_q <= final_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign final_value = final_q;
  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign walk        = walk_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// tb_tlc_phase_ctrl
// Drives tlc_phase_ctrl with a behavioural phase timer and compares every
// cycle against a reference model that tracks phases by name and remaining
// duration, with request flags kept as plain bits.
module tb_tlc_phase_ctrl;

  localparam int N    = 13;
  localparam int TGNS = 9;
  localparam int TGEW = 5;
  localparam int TY   = 2;
  localparam int TAR  = 1;
  localparam int TFL  = 3;

  localparam int P_NSG = 0;
  localparam int P_NSY = 1;
  localparam int P_ARA = 2;
  localparam int P_EWG = 3;
  localparam int P_EWY = 4;
  localparam int P_ARB = 5;
  localparam int P_FL  = 6;

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         side_car = 1'b0;
  logic         ped_req = 1'b0;
  logic         night_mode = 1'b0;
  logic         timer_done;
  logic [N-1:0] final_value;
  logic [2:0]   ns_light;
  logic [2:0]   ew_light;
  logic         walk;
  logic [2:0]   phase;
  logic [N-1:0] tmrCount;

  int errorCount = 0;
  int checkCount = 0;

  int mPh, mLeft;
  bit mCar, mPed, mWalk, mBlink;

  bit           doneBefore;
  logic [N-1:0] prevFinal;

  tlc_phase_ctrl #(
    .N(N), .T_GREEN_NS(TGNS), .T_GREEN_EW(TGEW), .T_YELLOW(TY),
    .T_ALL_RED(TAR), .T_FLASH(TFL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .timer_done  (timer_done),
    .side_car    (side_car),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .final_value (final_value),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // Behavioural timer: counts up and pulses when the count reaches final_value,
  // restarting at 0 on the following cycle.
  always @(posedge clk) begin
    if (reset || timer_done) tmrCount <= '0;
    else                     tmrCount <= tmrCount + 1'b1;
  end
  assign timer_done = (tmrCount == final_value);

  function automatic int codeOf(input int ph);
    case (ph)
      P_NSG:        return TGNS;
      P_EWG:        return TGEW;
      P_NSY, P_EWY: return TY;
      P_FL:         return TFL;
      default:      return TAR;
    endcase
  endfunction

  function automatic logic [5:0] expLamps(input int ph, input bit blink);
    case (ph)
      P_NSG:   return {L_G, L_R};
      P_NSY:   return {L_Y, L_R};
      P_EWG:   return {L_R, L_G};
      P_EWY:   return {L_R, L_Y};
      P_FL:    return blink ? {L_OFF, L_OFF} : {L_Y, L_R};
      default: return {L_R, L_R};
    endcase
  endfunction

  function automatic bit nonRed(input logic [2:0] lamp);
    return (lamp == L_G) || (lamp == L_Y);
  endfunction

  // Reference model: one call per rising edge with the inputs sampled there.
  task automatic modelEdge(input bit sc, input bit pr, input bit nm, input bit rst);
    int nxt;
    bit oldCar, oldPed;
    if (rst) begin
      mPh = P_ARB; mLeft = codeOf(P_ARB) + 1;
      mCar = 0; mPed = 0; mWalk = 0; mBlink = 0;
      return;
    end
    oldCar = mCar;
    oldPed = mPed;
    mCar = mCar | sc;
    mPed = mPed | pr;
    if (mLeft > 1) begin
      mLeft--;
      return;
    end
    case (mPh)
      P_NSG:   nxt = (oldCar || oldPed || nm) ? P_NSY : P_NSG;
      P_NSY:   nxt = P_ARA;
      P_ARA:   nxt = nm ? P_FL : P_EWG;
      P_EWG:   nxt = P_EWY;
      P_EWY:   nxt = P_ARB;
      P_ARB:   nxt = nm ? P_FL : P_NSG;
      default: nxt = nm ? P_FL : P_ARB;
    endcase
    mBlink = (nxt == P_FL && mPh == P_FL) ? !mBlink : 1'b0;
    if (nxt == P_EWG) begin
      mWalk = oldPed | pr;
      mCar = 0;
      mPed = 0;
    end else begin
      mWalk = 0;
    end
    mPh = nxt;
    mLeft = codeOf(nxt) + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time,
               observed, expected);
    end
  endtask

  task automatic checkCycle(input bit rst);
    logic [5:0] lamps;
    lamps = expLamps(mPh, mBlink);
    checkOutput("ns_light", 32'(ns_light), 32'(lamps[5:3]));
    checkOutput("ew_light", 32'(ew_light), 32'(lamps[2:0]));
    checkOutput("walk", 32'(walk), 32'(mWalk));
    checkOutput("final_value", 32'(final_value), 32'(codeOf(mPh)));
    checkOutput("one_road", 32'(!(nonRed(ns_light) && nonRed(ew_light))), 32'd1);
    if (!rst) checkOutput("final_hold", 32'((final_value == prevFinal) || doneBefore), 32'd1);
  endtask

  // One clock cycle: drive inputs, step the model at the edge, check after it.
  task automatic applyStimulus(input bit sc, input bit pr, input bit nm, input bit rst);
    side_car   = sc;
    ped_req    = pr;
    night_mode = nm;
    reset      = rst;
    doneBefore = (timer_done === 1'b1);
    prevFinal  = final_value;
    @(posedge clk);
    modelEdge(sc, pr, nm, rst);
    @(negedge clk);
    checkCycle(rst);
  endtask

  // Runs n cycles; the car request is pulsed on the first cycle only and a
  // pedestrian press optionally lands exactly on the edge entering EW_GREEN.
  task automatic runCycles(input int n, input bit carFirst, input bit nm,
                           input bit pedAtEntry);
    for (int i = 0; i < n; i++) begin
      applyStimulus(carFirst && i == 0,
                    pedAtEntry && mPh == P_ARA && mLeft == 1, nm, 1'b0);
    end
  endtask

  initial begin
    bit nmLevel;
    bit sc, pr, rst;

    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Idle: ALL_RED_B then NS_GREEN held and re-armed.
    runCycles(30, 0, 0, 0);

    // Car request a few cycles into NS_GREEN, served without walk.
    for (int i = 0; i < 20 && !(mPh == P_NSG && mLeft == codeOf(P_NSG) - 1); i++)
      applyStimulus(0, 0, 0, 0);
    runCycles(40, 1, 0, 0);

    // Car request again, pedestrian press only on the EW_GREEN entry edge.
    runCycles(40, 1, 0, 1);

    // Night mode through flashing, then back to normal operation.
    runCycles(50, 0, 1, 0);
    runCycles(30, 0, 0, 0);

    // Reset in the second cycle of EW_GREEN while walk is active.
    runCycles(1, 1, 0, 0);
    for (int i = 0; i < 60 && !(mPh == P_EWG && mLeft == codeOf(P_EWG)); i++)
      applyStimulus(0, mPh == P_ARA && mLeft == 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    runCycles(20, 0, 0, 0);

    // Random requests, night mode toggles and occasional resets.
    nmLevel = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 399) == 0) nmLevel = !nmLevel;
      sc  = ($urandom_range(0, 19) == 0);
      pr  = ($urandom_range(0, 19) == 0) ||
            (mPh == P_ARA && mLeft == 1 && $urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 1999) == 0);
      applyStimulus(sc, pr, nmLevel, rst);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
